// File: rtl/clb_cfg_pkg.sv
// Shared constants for the CLB configuration loader: field map of one CLB
// configuration word, power-on default, preamble and loader FSM states.
package clb_cfg_pkg;

    localparam int CFG_W = 37;

    localparam int MUX_W         = 2;
    localparam int MUX2_OFF      = 0;
    localparam int MUX3_OFF      = 2;
    localparam int MUX4_OFF      = 4;
    localparam int MUX5_OFF      = 6;
    localparam int MUX6_OFF      = 8;
    localparam int MEM_OFF       = 10;
    localparam int MEM_W         = 16;
    localparam int COMBO_OFF     = 26;
    localparam int COMBO_W       = 2;
    localparam int O2M1_0_OFF    = 28;
    localparam int O2M2_0_OFF    = 29;
    localparam int O2M3_0_OFF    = 30;
    localparam int O2M1_1_OFF    = 31;
    localparam int O2M2_1_OFF    = 32;
    localparam int O2M3_1_OFF    = 33;
    localparam int DQMUX1_OFF    = 34;
    localparam int DQMUX2_OFF    = 35;
    localparam int FLOPLATCH_OFF = 36;

    localparam logic [CFG_W-1:0] CFG_DEFAULT = 37'h0_3800_4582A;
    localparam logic [3:0]       PREAMBLE    = 4'b0010;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PARITY,
        COMMIT,
        ERROR
    } cfg_state_t;

endpackage

// File: rtl/clb_cfg_frame.sv
// One-frame deserialiser: MSB-first shift register, running even parity and
// bit counter. data_last flags the final data bit; par_ok judges the parity bit on din.
module clb_cfg_frame #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] word,
    output logic         data_last,
    output logic         par_ok
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt;
    logic          par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
            par  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            par <= 1'b0;
        end else if (shift_en) begin
            word <= {word[W-2:0], din};
            par  <= par ^ din;
            cnt  <= cnt + 1'b1;
        end
    end

    assign data_last = (cnt == CW'(W - 1));
    assign par_ok    = ~(par ^ din);

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial bitstream loader for the CLB array: preamble search, per-CLB parity
// checked frames into a shadow array, atomic commit to the active config.
module clb_cfg_loader #(
    parameter  int NUM_CLB = 4,
    parameter  int CFG_W   = 37,
    localparam int IDX_W   = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1
) (
    input  logic                     CCLK,
    input  logic                     RST_N,
    input  logic                     DIN,
    input  logic                     DIN_EN,
    input  logic                     PROG,
    output logic [NUM_CLB*CFG_W-1:0] CFG,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR,
    output logic [IDX_W-1:0]         FRAME_IDX
);
    import clb_cfg_pkg::*;

    localparam logic [CFG_W-1:0] DEF      = CFG_W'(CFG_DEFAULT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLB - 1);

    // assertion is immediate, release is aligned to CCLK
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    cfg_state_t                          state_q, state_d;
    logic [3:0]                          hist_q, hist_d;
    logic                                hist_any_q, hist_any_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic                                done_q, done_d;
    logic                                err_q, err_d;
    logic [NUM_CLB-1:0][CFG_W-1:0]       shadow_q, cfg_q;
    logic                                shift_en, frm_clr, slot_we, commit;
    logic [CFG_W-1:0]                    frm_word;
    logic                                data_last, par_ok;
    logic [3:0]                          hist_shift;

    clb_cfg_frame #(.W(CFG_W)) u_frame (
        .clk       (CCLK),
        .rst_n     (rst_n),
        .clr       (frm_clr),
        .shift_en  (shift_en),
        .din       (DIN),
        .word      (frm_word),
        .data_last (data_last),
        .par_ok    (par_ok)
    );

    assign hist_shift = {hist_q[2:0], DIN};

    // history clears to all-ones so a short run after a clear cannot alias the preamble
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        hist_any_d = hist_any_q;
        idx_d      = idx_q;
        done_d     = done_q;
        err_d      = err_q;
        shift_en   = 1'b0;
        frm_clr    = 1'b0;
        slot_we    = 1'b0;
        commit     = 1'b0;
        if (PROG) begin
            state_d    = IDLE;
            hist_d     = 4'b1111;
            hist_any_d = 1'b0;
            idx_d      = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (DIN_EN) begin
                    hist_d     = hist_shift;
                    hist_any_d = 1'b1;
                    if (hist_shift == PREAMBLE) begin
                        state_d    = LOAD;
                        idx_d      = '0;
                        frm_clr    = 1'b1;
                        done_d     = 1'b0;
                        hist_d     = 4'b1111;
                        hist_any_d = 1'b0;
                    end
                end
                LOAD: if (DIN_EN) begin
                    shift_en = 1'b1;
                    if (data_last) state_d = PARITY;
                end
                PARITY: if (DIN_EN) begin
                    if (par_ok) begin
                        slot_we = 1'b1;
                        frm_clr = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = COMMIT;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LOAD;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                end
                COMMIT: begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hist_q     <= 4'b1111;
            hist_any_q <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            shadow_q   <= '0;
            cfg_q      <= {NUM_CLB{DEF}};
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            hist_any_q <= hist_any_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (slot_we) shadow_q[idx_q] <= frm_word;
            if (commit)  cfg_q <= shadow_q;
        end
    end

    assign CFG       = cfg_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign FRAME_IDX = idx_q;
    assign BUSY      = (state_q == LOAD) || (state_q == PARITY) ||
                       ((state_q == IDLE) && hist_any_q);

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader: frame table, field-decode table, and
// hand sequences for parity error, DIN_EN gaps, PROG abort and async reset.
module tb_clb_cfg_loader;

    localparam int N = 4;
    localparam int W = 37;
    localparam logic [W-1:0] DEF = 37'h0_3800_4582A;

    logic           CCLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           DIN = 1'b0;
    logic           DIN_EN = 1'b0;
    logic           PROG = 1'b0;
    logic [N*W-1:0] CFG;
    logic           BUSY, DONE, ERR;
    logic [1:0]     FRAME_IDX;

    int checks = 0;
    int errors = 0;
    int gap_max = 0;
    bit guard = 1'b0;
    bit cfg_moved = 1'b0;
    logic [N*W-1:0] guard_val;

    typedef struct {
        int          clb;
        int          off;
        int          w;
        logic [15:0] exp;
    } fld_t;

    logic [W-1:0] fr [N];
    fld_t         ft [22];

    always #5 CCLK = ~CCLK;

    clb_cfg_loader #(.NUM_CLB(N), .CFG_W(W)) dut (
        .CCLK      (CCLK),
        .RST_N     (RST_N),
        .DIN       (DIN),
        .DIN_EN    (DIN_EN),
        .PROG      (PROG),
        .CFG       (CFG),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .FRAME_IDX (FRAME_IDX)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input logic [1:0] m2, m3, m4, m5, m6,
                                        input logic [15:0] mem, input logic [1:0] co,
                                        input logic [5:0] o2m, input logic [1:0] dq,
                                        input logic fl);
        return {fl, dq, o2m, co, mem, m6, m5, m4, m3, m2};
    endfunction

    task automatic tick();
        @(posedge CCLK);
        #1;
        if (guard && CFG !== guard_val) cfg_moved = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin
            DIN    = $urandom_range(0, 1);
            DIN_EN = 1'b0;
            tick();
        end
        DIN    = b;
        DIN_EN = 1'b1;
        tick();
        DIN_EN = 1'b0;
    endtask

    task automatic send_head();
        send_bit(1); send_bit(1); send_bit(1);
        send_bit(0); send_bit(0); send_bit(1); send_bit(0);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit bad);
        for (int b = W - 1; b >= 0; b--) send_bit(w[b]);
        send_bit((^w) ^ bad);
    endtask

    task automatic send_frames(input int rot);
        for (int f = 0; f < N; f++) send_frame(fr[(f + rot) % N], 1'b0);
    endtask

    task automatic chk_frames(input string tag, input int rot);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_slot%0d", tag, i), 64'(CFG[i*W +: W]), 64'(fr[(i + rot) % N]));
    endtask

    task automatic chk_default(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_def%0d", tag, i), 64'(CFG[i*W +: W]), 64'(DEF));
    endtask

    task automatic good_load(input string tag, input int rot);
        guard_val = CFG;
        cfg_moved = 1'b0;
        guard     = 1'b1;
        send_head();
        chk({tag, "_busy_load"}, 64'(BUSY), 64'd1);
        send_frames(rot);
        chk({tag, "_done_early"}, 64'(DONE), 64'd0);
        chk({tag, "_cfg_stable"}, 64'(cfg_moved), 64'd0);
        guard = 1'b0;
        tick();
        chk({tag, "_done"}, 64'(DONE), 64'd1);
        chk({tag, "_err"}, 64'(ERR), 64'd0);
        chk_frames(tag, rot);
    endtask

    initial begin
        logic [N*W-1:0] sh;
        logic [16:0]    m;

        fr[0] = mk(2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 16'h1234, 2'd1, 6'b101010, 2'b01, 1'b1);
        fr[1] = mk(2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 16'hFFFF, 2'd3, 6'b000000, 2'b10, 1'b0);
        fr[2] = mk(2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 16'hA5A5, 2'd2, 6'b111111, 2'b11, 1'b1);
        fr[3] = mk(2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 16'h0001, 2'd0, 6'b000000, 2'b00, 1'b0);

        ft[0]  = '{0, 0, 2, 16'h1};     ft[1]  = '{0, 2, 2, 16'h2};
        ft[2]  = '{0, 10, 16, 16'h1234}; ft[3]  = '{0, 26, 2, 16'h1};
        ft[4]  = '{0, 28, 1, 16'h0};    ft[5]  = '{0, 29, 1, 16'h1};
        ft[6]  = '{0, 33, 1, 16'h1};    ft[7]  = '{0, 34, 1, 16'h1};
        ft[8]  = '{0, 35, 1, 16'h0};    ft[9]  = '{0, 36, 1, 16'h1};
        ft[10] = '{1, 0, 2, 16'h3};     ft[11] = '{1, 6, 2, 16'h2};
        ft[12] = '{1, 10, 16, 16'hFFFF}; ft[13] = '{1, 26, 2, 16'h3};
        ft[14] = '{1, 35, 1, 16'h1};    ft[15] = '{2, 4, 2, 16'h2};
        ft[16] = '{2, 6, 2, 16'h3};     ft[17] = '{2, 10, 16, 16'hA5A5};
        ft[18] = '{2, 26, 2, 16'h2};    ft[19] = '{2, 31, 1, 16'h1};
        ft[20] = '{3, 8, 2, 16'h3};     ft[21] = '{3, 10, 16, 16'h0001};

        // reset
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (4) tick();
        chk_default("rst");
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_idx", 64'(FRAME_IDX), 64'd0);

        // parity error in frame 1
        send_head();
        send_frame(fr[0], 1'b0);
        chk("perr_idx1", 64'(FRAME_IDX), 64'd1);
        send_frame(fr[1], 1'b1);
        chk("perr_err", 64'(ERR), 64'd1);
        chk("perr_busy", 64'(BUSY), 64'd0);
        send_frame(fr[2], 1'b0);
        send_head();
        send_frame(fr[3], 1'b0);
        chk("perr_sticky", 64'(ERR), 64'd1);
        chk("perr_done", 64'(DONE), 64'd0);
        chk_default("perr");
        PROG = 1'b1;
        tick();
        PROG = 1'b0;
        chk("prog_clr_err", 64'(ERR), 64'd0);

        // gap-free load plus field decode
        good_load("load", 0);
        for (int k = 0; k < 22; k++) begin
            sh = CFG >> (ft[k].clb * W + ft[k].off);
            m  = (17'd1 << ft[k].w) - 17'd1;
            chk($sformatf("fld%0d", k), 64'(sh[15:0] & m[15:0]), 64'(ft[k].exp));
        end
        chk("load_busy_idle", 64'(BUSY), 64'd0);

        // async reset in the middle of a load
        send_head();
        for (int b = W - 1; b >= W - 20; b--) send_bit(fr[1][b]);
        #2 RST_N = 1'b0;
        #1;
        chk_default("arst");
        chk("arst_done", 64'(DONE), 64'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (4) tick();

        // DIN_EN gaps
        gap_max = 5;
        good_load("gap", 0);
        gap_max = 0;

        // PROG with DIN_EN mid-frame 2
        send_head();
        send_frame(fr[0], 1'b0);
        send_frame(fr[1], 1'b0);
        for (int b = W - 1; b >= W - 15; b--) send_bit(fr[2][b]);
        DIN    = 1'b0;
        DIN_EN = 1'b1;
        PROG   = 1'b1;
        tick();
        PROG   = 1'b0;
        DIN_EN = 1'b0;
        chk("prog_busy", 64'(BUSY), 64'd0);
        chk("prog_done", 64'(DONE), 64'd0);
        chk_frames("prog_keep", 0);
        send_bit(0); send_bit(1); send_bit(0);
        good_load("reload", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
